// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_if
// Description : Bundle of the two requester ports (A = CPU, B = Ethmac DMA)
//               and the external asynchronous SRAM pins seen by sram_arbiter.
//               The slave modport is the arbiter's view; the master modport
//               is the view of whatever drives the requests and models the
//               SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if;

  // Port A (CPU)
  logic        i_a_req;
  logic        i_a_we;
  logic [22:0] i_a_addr;
  logic [7:0]  i_a_wdata;
  logic        o_a_ack;
  logic [7:0]  o_a_rdata;

  // Port B (Ethmac DMA)
  logic        i_b_req;
  logic        i_b_we;
  logic [22:0] i_b_addr;
  logic [7:0]  i_b_wdata;
  logic        o_b_ack;
  logic [7:0]  o_b_rdata;

  // External SRAM
  logic [3:0]  o_sram_cs_n;
  logic        o_sram_read_n;
  logic        o_sram_write_n;
  logic [20:0] o_sram_addr;
  logic [7:0]  o_sram_wdata;
  logic        o_sram_data_oe;
  logic [7:0]  i_sram_rdata;

  modport slave (
    input  i_a_req, i_a_we, i_a_addr, i_a_wdata,
    input  i_b_req, i_b_we, i_b_addr, i_b_wdata,
    input  i_sram_rdata,
    output o_a_ack, o_a_rdata, o_b_ack, o_b_rdata,
    output o_sram_cs_n, o_sram_read_n, o_sram_write_n,
    output o_sram_addr, o_sram_wdata, o_sram_data_oe
  );

  modport master (
    output i_a_req, i_a_we, i_a_addr, i_a_wdata,
    output i_b_req, i_b_we, i_b_addr, i_b_wdata,
    output i_sram_rdata,
    input  o_a_ack, o_a_rdata, o_b_ack, o_b_rdata,
    input  o_sram_cs_n, o_sram_read_n, o_sram_write_n,
    input  o_sram_addr, o_sram_wdata, o_sram_data_oe
  );

endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Two-port arbiter in front of four 8-bit asynchronous SRAM
//               chips. Each access runs IDLE -> SETUP -> ACCESS(WAIT_STATES)
//               -> HOLD -> IDLE, with all SRAM pins driven from registers.
//               Simultaneous requests are resolved round robin.
//               Build option: define SRAM_ARB_FIXED_PRIO_EN to give port A
//               fixed priority (the round-robin pointer is then removed).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
  parameter int WAIT_STATES = 2   // strobe-low cycles, legal 1..15
) (
  input  logic          i_clk,
  input  logic          i_reset,
  sram_arbiter_if.slave bus
);

  // Down-counter start value: ACCESS ends when the counter has reached zero.
  localparam logic [3:0] C_WS_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched transaction and registered pin state
  logic [3:0]  r_cnt,       w_cnt_nxt;
  logic        r_we,        w_we_nxt;
  logic        r_grant_b,   w_grant_b_nxt;
  logic [3:0]  r_cs_n,      w_cs_n_nxt;
  logic        r_read_n,    w_read_n_nxt;
  logic        r_write_n,   w_write_n_nxt;
  logic [20:0] r_addr,      w_addr_nxt;
  logic [7:0]  r_wdata,     w_wdata_nxt;
  logic        r_oe,        w_oe_nxt;
  logic        r_a_ack,     w_a_ack_nxt;
  logic        r_b_ack,     w_b_ack_nxt;
  logic [7:0]  r_a_rdata,   w_a_rdata_nxt;
  logic [7:0]  r_b_rdata,   w_b_rdata_nxt;

  // Request selection
  logic        w_any_req;
  logic        w_grant;
  logic        w_pick_b;
  logic        w_sel_we;
  logic [22:0] w_sel_addr;
  logic [7:0]  w_sel_wdata;

  assign w_any_req = bus.i_a_req | bus.i_b_req;
  assign w_grant   = (r_state == S_IDLE) && w_any_req;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // B is only chosen when A is not asking.
  assign w_pick_b = ~bus.i_a_req;
`else
  logic r_last_b;   // 1 = port B won the most recent grant

  // On a tie, the port that did not win last time gets the grant.
  assign w_pick_b = bus.i_b_req & (~bus.i_a_req | ~r_last_b);

  // Round-robin pointer: remember the winner of every grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_b <= 1'b1;
    end else if (w_grant) begin
      r_last_b <= w_pick_b;
    end
  end
`endif

  assign w_sel_we    = w_pick_b ? bus.i_b_we    : bus.i_a_we;
  assign w_sel_addr  = w_pick_b ? bus.i_b_addr  : bus.i_a_addr;
  assign w_sel_wdata = w_pick_b ? bus.i_b_wdata : bus.i_a_wdata;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next pin values; pins are registered so every SRAM
  // signal changes cleanly on the clock edge that enters the new state.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_we_nxt      = r_we;
    w_grant_b_nxt = r_grant_b;
    w_cs_n_nxt    = r_cs_n;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_oe_nxt      = r_oe;
    w_read_n_nxt  = 1'b1;
    w_write_n_nxt = 1'b1;
    w_a_ack_nxt   = 1'b0;
    w_b_ack_nxt   = 1'b0;
    w_a_rdata_nxt = r_a_rdata;
    w_b_rdata_nxt = r_b_rdata;

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt   = S_SETUP;
          w_grant_b_nxt = w_pick_b;
          w_we_nxt      = w_sel_we;
          w_cs_n_nxt    = ~(4'b0001 << w_sel_addr[22:21]);
          w_addr_nxt    = w_sel_addr[20:0];
          w_wdata_nxt   = w_sel_wdata;
          w_oe_nxt      = w_sel_we;
        end
      end

      S_SETUP: begin
        w_state_nxt   = S_ACCESS;
        w_cnt_nxt     = C_WS_LOAD;
        w_read_n_nxt  = r_we;
        w_write_n_nxt = ~r_we;
      end

      S_ACCESS: begin
        if (r_cnt == 4'd0) begin
          // Last strobe cycle: release strobe, ack, and capture read data.
          w_state_nxt = S_HOLD;
          w_a_ack_nxt = ~r_grant_b;
          w_b_ack_nxt = r_grant_b;
          if (!r_we) begin
            if (r_grant_b) begin
              w_b_rdata_nxt = bus.i_sram_rdata;
            end else begin
              w_a_rdata_nxt = bus.i_sram_rdata;
            end
          end
        end else begin
          w_cnt_nxt     = r_cnt - 4'd1;
          w_read_n_nxt  = r_we;
          w_write_n_nxt = ~r_we;
        end
      end

      S_HOLD: begin
        // cs/addr/data were held through HOLD; release them for IDLE.
        w_state_nxt = S_IDLE;
        w_cs_n_nxt  = 4'hF;
        w_oe_nxt    = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Transaction latches and output pin registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_grant_b <= 1'b0;
      r_cs_n    <= 4'hF;
      r_read_n  <= 1'b1;
      r_write_n <= 1'b1;
      r_addr    <= 21'd0;
      r_wdata   <= 8'd0;
      r_oe      <= 1'b0;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_rdata <= 8'd0;
      r_b_rdata <= 8'd0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_we      <= w_we_nxt;
      r_grant_b <= w_grant_b_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_read_n  <= w_read_n_nxt;
      r_write_n <= w_write_n_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_oe      <= w_oe_nxt;
      r_a_ack   <= w_a_ack_nxt;
      r_b_ack   <= w_b_ack_nxt;
      r_a_rdata <= w_a_rdata_nxt;
      r_b_rdata <= w_b_rdata_nxt;
    end
  end

  assign bus.o_sram_cs_n    = r_cs_n;
  assign bus.o_sram_read_n  = r_read_n;
  assign bus.o_sram_write_n = r_write_n;
  assign bus.o_sram_addr    = r_addr;
  assign bus.o_sram_wdata   = r_wdata;
  assign bus.o_sram_data_oe = r_oe;
  assign bus.o_a_ack        = r_a_ack;
  assign bus.o_b_ack        = r_b_ack;
  assign bus.o_a_rdata      = r_a_rdata;
  assign bus.o_b_rdata      = r_b_rdata;

endmodule
`default_nettype wire
